mult_div_seq: RTL



---
 rtl/mult_div_seq_pkg.sv | 15 +
 rtl/mult_div_seq_step.sv | 52 +++++
 rtl/mult_div_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mult_div_seq_pkg.sv
// Shared types and constants for the mult_div_seq sequencer.
package mult_div_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_div_seq_step.sv
// One iteration of the multiply/divide datapath: Booth or shift-add step for MULT,
// restoring-division step for DIV. Purely combinational.
module mult_div_seq_step
  import mult_div_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic             op,
  input  logic             signed_mode,
  output logic [2*WIDTH:0] acc_next
);

  logic [WIDTH:0]   hi_ext;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_new;
  logic [WIDTH+1:0] diff;
  logic             q_bit;

  // MULT layout {hi, lo, q-1}; DIV layout {partial remainder (W+1), quotient (W)}.
  // The add is done one bit wider so the shifted-in MSB is exact even for -2^(W-1).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hi_ext   = {signed_mode & acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    m_ext    = {signed_mode & operand[WIDTH-1], operand};
    sum      = hi_ext;
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, operand};
    q_bit    = ~diff[WIDTH+1];
    rem_new  = q_bit ? diff[WIDTH:0] : shifted;
    acc_next = acc;

    if (op == OP_MULT) begin
      if (signed_mode) begin
        case (acc[1:0])
          2'b01:   sum = hi_ext + m_ext;
          2'b10:   sum = hi_ext - m_ext;
          default: sum = hi_ext;
        endcase
      end else if (acc[1]) begin
        sum = hi_ext + m_ext;
      end
      acc_next = {sum, acc[WIDTH:1]};
    end else begin
      acc_next = {rem_new, acc[WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Multi-cycle signed multiply/divide sequencer (one bit per clock, HI/LO results).
// Optional macro MULT_DIV_SEQ_UNSIGNED_EN adds the is_unsigned port for MULTU/DIVU.
module mult_div_seq
  import mult_div_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULT_DIV_SEQ_UNSIGNED_EN
  ,
  input  logic             is_unsigned
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_next;
  logic [WIDTH-1:0] operand;
  logic             op_q;
  logic             sgn_q;
  logic             neg_quo;
  logic             neg_rem;

  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_by_zero;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

`ifdef MULT_DIV_SEQ_UNSIGNED_EN
  assign sgn_in = ~is_unsigned;
`else
  assign sgn_in = 1'b1;
`endif

  // Division runs on magnitudes; signs are reapplied on the final edge.
  assign a_neg       = sgn_in & a[WIDTH-1];
  assign b_neg       = sgn_in & b[WIDTH-1];
  assign a_mag       = a_neg ? -a : a;
  assign b_mag       = b_neg ? -b : b;
  assign div_by_zero = (op == OP_DIV) && (b == '0);

  assign quo     = acc_next[WIDTH-1:0];
  assign rem     = acc_next[2*WIDTH-1:WIDTH];
  assign quo_fix = neg_quo ? -quo : quo;
  assign rem_fix = neg_rem ? -rem : rem;

  mult_div_seq_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc        (acc),
    .operand    (operand),
    .op         (op_q),
    .signed_mode(sgn_q),
    .acc_next   (acc_next)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = div_by_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      op_q     <= OP_MULT;
      sgn_q    <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (div_by_zero) begin
              div_zero <= 1'b1;
            end else begin
              div_zero <= 1'b0;
              cnt      <= '0;
              op_q     <= op;
              sgn_q    <= sgn_in;
              neg_quo  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              if (op == OP_MULT) begin
                acc     <= {{WIDTH{1'b0}}, b, 1'b0};
                operand <= a;
              end else begin
                acc     <= {{(WIDTH + 1){1'b0}}, a_mag};
                operand <= b_mag;
              end
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            if (op_q == OP_MULT) begin
              {hi, lo} <= acc_next[2*WIDTH:1];
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
